// File: rtl/line_mem_responder.sv
// Cache-line backing store that answers dcache requests after a fixed, programmable latency.
// Keeps wrapping read/write completion counters for miss accounting.
module line_mem_responder #(
   parameter int unsigned LINE_W   = 256,
   parameter int unsigned DEPTH    = 512,
   parameter int unsigned ADDR_LSB = 5,
   parameter int unsigned LATENCY  = 10,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  rd_cnt_o,
   output logic [CNT_W-1:0]  wr_cnt_o
);

   localparam int unsigned IdxW    = $clog2(DEPTH);
   localparam logic [7:0]  LatInit = 8'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StWait, StAck, StDone} state_e;

   logic [LINE_W-1:0] memory [DEPTH];

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              wr_q, wr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              ack_q, ack_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

   logic [IdxW-1:0]   addr_idx;
   logic              unused_addr;

   // Upper address bits wrap modulo DEPTH; byte-offset bits are don't-care.
   assign addr_idx    = addr_i[ADDR_LSB +: IdxW];
   assign unused_addr = ^{addr_i[31:ADDR_LSB+IdxW], addr_i[ADDR_LSB-1:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      ack_d    = ack_q;
      data_d   = data_q;
      busy_d   = busy_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (enable_i) begin
               idx_d   = addr_idx;
               wr_d    = write_i;
               wdata_d = data_i;
               busy_d  = 1'b1;
               cnt_d   = LatInit;
               if (LATENCY == 1) begin
                  state_d = StAck;
                  ack_d   = 1'b1;
                  data_d  = write_i ? '0 : memory[addr_idx];
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = StAck;
               ack_d   = 1'b1;
               data_d  = wr_q ? '0 : memory[idx_q];
            end
         end
         StAck: begin
            state_d = StDone;
            ack_d   = 1'b0;
            data_d  = '0;
            busy_d  = 1'b0;
            if (wr_q) wr_cnt_d = wr_cnt_q + CNT_W'(1);
            else      rd_cnt_d = rd_cnt_q + CNT_W'(1);
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         ack_q    <= 1'b0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         ack_q    <= ack_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Write commits on the edge leaving ACK; a reset before then leaves the array untouched.
   always_ff @(posedge clk_i) begin
      if (state_q == StAck && wr_q) memory[idx_q] <= wdata_q;
   end

   assign ack_o    = ack_q;
   assign data_o   = data_q;
   assign busy_o   = busy_q;
   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench: dut0 uses LATENCY=10, dut1 uses LATENCY=1 with 2-bit counters.
// Both share the request bus; each is checked only in its own section.
module tb_line_mem_responder;

   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   addr = '0;
   logic [LW-1:0] wdata = '0;
   logic          enable = 1'b0;
   logic          write = 1'b0;

   logic          ack0, busy0, ack1, busy1;
   logic [LW-1:0] data0, data1;
   logic [15:0]   rd_cnt0, wr_cnt0;
   logic [1:0]    rd_cnt1, wr_cnt1;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   localparam logic [LW-1:0] Ones = '1;
   localparam logic [LW-1:0] PatB = {8{32'hB0B0_0257}};
   localparam logic [LW-1:0] PatC = {8{32'hC0C0_0002}};
   localparam logic [LW-1:0] PatP = {8{32'hDEAD_BEEF}};

   line_mem_responder #(.LATENCY(10)) dut0 (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(enable),
      .write_i(write), .ack_o(ack0), .data_o(data0), .busy_o(busy0),
      .rd_cnt_o(rd_cnt0), .wr_cnt_o(wr_cnt0)
   );

   line_mem_responder #(.DEPTH(16), .LATENCY(1), .CNT_W(2)) dut1 (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(enable),
      .write_i(write), .ack_o(ack1), .data_o(data1), .busy_o(busy1),
      .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
   task automatic request(input bit sel, input logic [31:0] a, input bit wr,
                          input logic [LW-1:0] d, input bit keep, output int c,
                          output int ack_at, output logic [LW-1:0] rd,
                          output logic [15:0] rc, output logic [15:0] wc);
      bit seen;
      seen   = 1'b0;
      addr   = a;
      write  = wr;
      wdata  = d;
      enable = 1'b1;
      c      = cyc;
      ack_at = -1;
      rd     = '0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (sel ? ack1 : ack0) begin
            seen   = 1'b1;
            ack_at = cyc;
            rd     = sel ? data1 : data0;
            chk("busy_in_ack", LW'(sel ? busy1 : busy0), LW'(1));
         end
      end
      chk("ack_seen", LW'(seen), LW'(1));
      if (!keep) enable = 1'b0;
      @(negedge clk);
      chk("done_ack_low", LW'(sel ? ack1 : ack0), '0);
      chk("done_data_zero", sel ? data1 : data0, '0);
      chk("done_busy_low", LW'(sel ? busy1 : busy0), '0);
      rc = sel ? 16'(rd_cnt1) : rd_cnt0;
      wc = sel ? 16'(wr_cnt1) : wr_cnt0;
      @(negedge clk);
   endtask

   int            c, a1, a2;
   logic [LW-1:0] rd;
   logic [15:0]   rc, wc;
   bit            abort_ack;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ack", LW'(ack0), '0);
      chk("rst_data", data0, '0);
      chk("rst_busy", LW'(busy0), '0);
      chk("rst_rdcnt", LW'(rd_cnt0), '0);
      chk("rst_wrcnt", LW'(wr_cnt0), '0);
      dut0.memory[0]   = LW'(5);
      dut0.memory[1]   = '0;
      dut0.memory[2]   = PatC;
      dut0.memory[257] = PatB;
      rst = 1'b0;
      @(negedge clk);

      // Plain read of line 0.
      request(0, 32'h0000_0000, 0, '0, 0, c, a1, rd, rc, wc);
      chk("rd0_latency", LW'(a1 - c), LW'(10));
      chk("rd0_data", rd, LW'(5));
      chk("rd0_rdcnt", LW'(rc), LW'(1));

      // Write line 1 then read it back.
      request(0, 32'h0000_0020, 1, Ones, 0, c, a1, rd, rc, wc);
      chk("wr1_latency", LW'(a1 - c), LW'(10));
      chk("wr1_data_o_zero", rd, '0);
      chk("wr1_wrcnt", LW'(wc), LW'(1));
      chk("wr1_mem", dut0.memory[1], Ones);
      request(0, 32'h0000_0020, 0, '0, 0, c, a1, rd, rc, wc);
      chk("rd1_data", rd, Ones);
      chk("rd1_rdcnt", LW'(rc), LW'(2));

      // Upper address bits wrap to line 1.
      request(0, 32'h4000_0020, 1, PatP, 0, c, a1, rd, rc, wc);
      chk("wrap_mem1", dut0.memory[1], PatP);
      chk("wrap_mem257", dut0.memory[257], PatB);
      chk("wrap_wrcnt", LW'(wc), LW'(2));

      // Back-to-back reads with enable held high through DONE.
      request(0, 32'h0000_0000, 0, '0, 1, c, a1, rd, rc, wc);
      chk("b2b_first_data", rd, LW'(5));
      request(0, 32'h0000_0020, 0, '0, 0, c, a2, rd, rc, wc);
      chk("b2b_gap", LW'(a2 - a1), LW'(12));
      chk("b2b_second_data", rd, PatP);
      chk("b2b_rdcnt", LW'(rc), LW'(4));

      // Reset in the middle of a write to line 2.
      addr   = 32'h0000_0040;
      write  = 1'b1;
      wdata  = Ones;
      enable = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_busy_before", LW'(busy0), LW'(1));
      enable = 1'b0;
      rst    = 1'b1;
      #1;
      chk("abort_ack_low", LW'(ack0), '0);
      chk("abort_busy_low", LW'(busy0), '0);
      @(negedge clk);
      rst = 1'b0;
      abort_ack = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (ack0) abort_ack = 1'b1;
      end
      chk("abort_no_ack", LW'(abort_ack), '0);
      chk("abort_mem2", dut0.memory[2], PatC);
      chk("abort_wrcnt", LW'(wr_cnt0), '0);
      request(0, 32'h0000_0040, 0, '0, 0, c, a1, rd, rc, wc);
      chk("post_abort_latency", LW'(a1 - c), LW'(10));
      chk("post_abort_data", rd, PatC);
      chk("post_abort_rdcnt", LW'(rc), LW'(1));

      // LATENCY=1 instance: five reads, 2-bit counter wraps.
      repeat (20) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 5; k++) dut1.memory[k] = LW'(k + 16);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         request(1, 32'(k * 32), 0, '0, 0, c, a1, rd, rc, wc);
         chk("l1_latency", LW'(a1 - c), LW'(1));
         chk("l1_data", rd, LW'(k + 16));
         chk("l1_rdcnt", LW'(rc), LW'((k + 1) % 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
